// File: rtl/dna_match_controller.sv
// Anchored pattern matcher: walks a small pattern program (literals, wildcards,
// alternations, exact and greedy bounded repeats) against a valid/ready nucleotide stream.
module dna_match_controller #(
  parameter int NW = 2,
  parameter int PW = 8,
  parameter int PD = 16,
  parameter int AW = $clog2(PD)
) (
  input  logic          clock,
  input  logic          reset_L,
  input  logic          start,
  input  logic [NW-1:0] nuc,
  input  logic          nuc_valid,
  input  logic          nuc_last,
  output logic          nuc_ready,
  output logic [AW-1:0] pat_addr,
  input  logic [PW-1:0] pat_data,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_CONSUME, S_ALTLOAD, S_REP_EXACT, S_REP_UPTO, S_FIN
  } state_t;

  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [4:0]    count_q;
  logic [NW-1:0] cand_q [3];
  logic [1:0]    alt_n_q;
  logic [1:0]    alt_idx_q;
  logic          alt_mode_q;
  logic          ended_q;
  logic          busy_q;
  logic          done_q;
  logic          found_q;
  logic          err_q;

  logic [7:0]    ent;
  logic          is_end, is_lit, is_any, is_alt2, is_alt3, is_exact, is_upto;
  logic          elem_ok, elem_hit, alt_hit, cons_hit, pc_last, fire;
  logic [NW-1:0] lit_nuc;

  assign ent      = 8'(pat_data);
  assign is_end   = (ent == 8'h00);
  assign is_lit   = (ent[7:2] == 6'b000100);
  assign is_any   = (ent == 8'h20);
  assign is_alt2  = (ent == 8'h21);
  assign is_alt3  = (ent == 8'h22);
  assign is_exact = (ent[7:4] == 4'h0) && (ent[3:0] != 4'h0);
  assign is_upto  = (ent[7:4] == 4'h3);
  assign lit_nuc  = NW'(ent[1:0]);
  assign elem_ok  = is_lit | is_any;
  assign elem_hit = is_any | (is_lit && (nuc == lit_nuc));
  assign alt_hit  = (nuc == cand_q[0]) || (nuc == cand_q[1]) ||
                    ((alt_n_q == 2'd3) && (nuc == cand_q[2]));
  assign cons_hit = alt_mode_q ? alt_hit : elem_hit;
  assign pc_last  = (pc_q == AW'(PD - 1));

  // UPTO only accepts a symbol it will match, so a mismatch stays offered downstream.
  always_comb begin
    nuc_ready = 1'b0;
    case (state_q)
      S_CONSUME:   nuc_ready = !ended_q;
      S_REP_EXACT: nuc_ready = !ended_q && elem_ok && (count_q != 5'd0);
      S_REP_UPTO:  nuc_ready = !ended_q && elem_ok && (count_q != 5'd0) && elem_hit;
      default:     nuc_ready = 1'b0;
    endcase
  end

  assign fire     = nuc_valid && nuc_ready;
  assign pat_addr = pc_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign found    = found_q;
  assign err      = err_q;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      count_q    <= '0;
      for (int i = 0; i < 3; i++) cand_q[i] <= '0;
      alt_n_q    <= '0;
      alt_idx_q  <= '0;
      alt_mode_q <= 1'b0;
      ended_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      found_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (fire && nuc_last) ended_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_q       <= '0;
            found_q    <= 1'b0;
            err_q      <= 1'b0;
            ended_q    <= 1'b0;
            alt_mode_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_DECODE;
          end
        end
        S_DECODE: begin
          alt_mode_q <= 1'b0;
          if (is_end) begin
            found_q <= 1'b1; busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_FIN;
          end else if (elem_ok) begin
            state_q <= S_CONSUME;
          end else if ((is_alt2 || is_alt3 || is_exact || is_upto) && !pc_last) begin
            pc_q <= pc_q + AW'(1);
            if (is_alt2 || is_alt3) begin
              alt_n_q   <= is_alt3 ? 2'd3 : 2'd2;
              alt_idx_q <= 2'd0;
              state_q   <= S_ALTLOAD;
            end else if (is_exact) begin
              count_q <= {1'b0, ent[3:0]};
              state_q <= S_REP_EXACT;
            end else begin
              count_q <= 5'd16 - {1'b0, ent[3:0]};
              state_q <= S_REP_UPTO;
            end
          end else begin
            err_q <= 1'b1; busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_FIN;
          end
        end
        S_CONSUME: begin
          if (ended_q || (fire && !cons_hit)) begin
            busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_FIN;
          end else if (fire) begin
            if (pc_last) begin
              err_q <= 1'b1; busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_FIN;
            end else begin
              pc_q <= pc_q + AW'(1); state_q <= S_DECODE;
            end
          end
        end
        S_ALTLOAD: begin
          if (!is_lit || ((alt_idx_q != alt_n_q - 2'd1) && pc_last)) begin
            err_q <= 1'b1; busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_FIN;
          end else begin
            cand_q[alt_idx_q] <= lit_nuc;
            if (alt_idx_q == alt_n_q - 2'd1) begin
              alt_mode_q <= 1'b1;
              state_q    <= S_CONSUME;
            end else begin
              alt_idx_q <= alt_idx_q + 2'd1;
              pc_q      <= pc_q + AW'(1);
            end
          end
        end
        S_REP_EXACT, S_REP_UPTO: begin
          if (!elem_ok) begin
            err_q <= 1'b1; busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_FIN;
          end else if ((count_q == 5'd0) || (state_q == S_REP_UPTO &&
                       (ended_q || (nuc_valid && !elem_hit)))) begin
            if (pc_last) begin
              err_q <= 1'b1; busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_FIN;
            end else begin
              pc_q <= pc_q + AW'(1); state_q <= S_DECODE;
            end
          end else if (ended_q || (fire && !elem_hit)) begin
            busy_q <= 1'b0; done_q <= 1'b1; state_q <= S_FIN;
          end else if (fire) begin
            count_q <= count_q - 5'd1;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_match_controller.sv
// Directed table plus randomized patterns/streams checked against a pattern interpreter.
module tb_dna_match_controller;

  logic       clock = 1'b0;
  logic       reset_L;
  logic       start;
  logic [1:0] nuc;
  logic       nuc_valid;
  logic       nuc_last;
  logic       nuc_ready;
  logic [3:0] pat_addr;
  logic [7:0] pat_data;
  logic       busy, done, found, err;

  logic [7:0] mem [16];
  int         strm [32];
  int         slen;
  bit         gaps;
  int         n_checks = 0;
  int         n_fail = 0;

  assign pat_data = mem[pat_addr];

  dna_match_controller dut (
    .clock(clock), .reset_L(reset_L), .start(start), .nuc(nuc),
    .nuc_valid(nuc_valid), .nuc_last(nuc_last), .nuc_ready(nuc_ready),
    .pat_addr(pat_addr), .pat_data(pat_data), .busy(busy), .done(done),
    .found(found), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  function automatic bit is_lit(input logic [7:0] x);
    return (x >= 8'h10) && (x <= 8'h13);
  endfunction

  function automatic bit hits(input logic [7:0] x, input int n);
    return (x == 8'h20) || (is_lit(x) && (int'(x) - 16 == n));
  endfunction

  // Interprets the pattern program directly: returns found, err and symbols consumed.
  function automatic void ref_model(output int f, output int e, output int c);
    int pc, pos, k, reps;
    bit fin, ok, hit, upto;
    logic [7:0] x, el;
    f = 0; e = 0; pc = 0; pos = 0; fin = 0;
    while (!fin) begin
      x = mem[pc];
      if (x == 8'h00) begin
        f = 1; fin = 1;
      end else if (is_lit(x) || x == 8'h20) begin
        if (pos >= slen) fin = 1;
        else begin
          pos++;
          if (!hits(x, strm[pos-1])) fin = 1;
          else if (pc == 15) begin e = 1; fin = 1; end
          else pc++;
        end
      end else if (x == 8'h21 || x == 8'h22) begin
        k = (x == 8'h21) ? 2 : 3;
        ok = 1;
        for (int j = 1; j <= k; j++)
          if (pc + j > 15 || !is_lit(mem[pc+j])) ok = 0;
        if (!ok) begin e = 1; fin = 1; end
        else if (pos >= slen) fin = 1;
        else begin
          hit = 0;
          for (int j = 1; j <= k; j++) if (hits(mem[pc+j], strm[pos])) hit = 1;
          pos++;
          if (!hit) fin = 1;
          else if (pc + k == 15) begin e = 1; fin = 1; end
          else pc = pc + k + 1;
        end
      end else if ((x >= 8'h01 && x <= 8'h0F) || (x >= 8'h30 && x <= 8'h3F)) begin
        upto = (x >= 8'h30);
        reps = upto ? 16 - int'(x[3:0]) : int'(x[3:0]);
        if (pc == 15 || !(is_lit(mem[pc+1]) || mem[pc+1] == 8'h20)) begin
          e = 1; fin = 1;
        end else begin
          el = mem[pc+1];
          if (upto) begin
            while (reps > 0 && pos < slen && hits(el, strm[pos])) begin pos++; reps--; end
          end else begin
            while (reps > 0 && !fin) begin
              if (pos >= slen) fin = 1;
              else begin
                pos++;
                if (!hits(el, strm[pos-1])) fin = 1; else reps--;
              end
            end
          end
          if (!fin) begin
            if (pc + 1 == 15) begin e = 1; fin = 1; end
            else pc = pc + 2;
          end
        end
      end else begin
        e = 1; fin = 1;
      end
    end
    c = pos;
  endfunction

  task automatic run_match(input string nm, output int cons, output int fnd,
                           output int er);
    int  pos;
    bit  fire, got;
    pos = 0; fnd = -1; er = -1; got = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    chk({nm, "_busy_after_start"}, busy, 1);
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (done) begin got = 1; fnd = found; er = err; break; end
      nuc_valid = (pos < slen) && (!gaps || $urandom_range(0, 3) != 0);
      nuc       = (pos < slen) ? 2'(strm[pos]) : 2'd0;
      nuc_last  = (pos == slen - 1);
      #1;
      fire = nuc_valid && nuc_ready;
      @(posedge clock);
      if (fire) pos++;
      @(negedge clock);
    end
    nuc_valid = 1'b0;
    nuc_last  = 1'b0;
    cons = pos;
    chk({nm, "_done_seen"}, got, 1);
    if (got) begin
      chk({nm, "_busy_at_done"}, busy, 0);
      @(negedge clock);
      chk({nm, "_done_one_cycle"}, done, 0);
      chk({nm, "_result_held"}, {found, err}, {fnd[0], er[0]});
    end
  endtask

  typedef struct {
    logic [127:0] pat;
    logic [47:0]  str;
    int           len;
    int           f;
    int           e;
    int           c;
  } vec_t;

  function automatic vec_t v(input logic [127:0] p, input logic [47:0] s, input int len,
                             input int f, input int e, input int c);
    vec_t t;
    t.pat = p; t.str = s; t.len = len; t.f = f; t.e = e; t.c = c;
    return t;
  endfunction

  vec_t tbl [15];

  initial begin
    int cons, fnd, er, mf, me, mc, plen, alph, r, len;
    string nm;

    tbl[0]  = v({8'h00, 8'h20, 8'h12}, {2'd3, 2'd2}, 2, 1, 0, 2);
    tbl[1]  = v({8'h00, 8'h11, 8'h03}, {2'd0, 2'd1, 2'd1}, 3, 0, 0, 3);
    tbl[2]  = v({8'h00, 8'h11, 8'h03}, {2'd1, 2'd1, 2'd1}, 3, 1, 0, 3);
    tbl[3]  = v({8'h00, 8'h13, 8'h10, 8'h3D}, {2'd3, 2'd0, 2'd0}, 3, 1, 0, 3);
    tbl[4]  = v({8'h00, 8'h13, 8'h12, 8'h10, 8'h22}, {2'd1}, 1, 0, 0, 1);
    tbl[5]  = v({8'h00, 8'h13, 8'h12, 8'h10, 8'h22}, {2'd2}, 1, 1, 0, 1);
    tbl[6]  = v({8'h15}, {2'd0}, 1, 0, 1, 0);
    tbl[7]  = v({8'h00, 8'h10, 8'h20, 8'h21}, {2'd0}, 1, 0, 1, 0);
    tbl[8]  = v({16{8'h20}}, {20{2'd1}}, 20, 0, 1, 16);
    tbl[9]  = v({8'h00, 8'h10, 8'h10}, {2'd0}, 1, 0, 0, 1);
    tbl[10] = v({8'h00, 8'h20, 8'h3F}, {2'd2, 2'd1}, 2, 1, 0, 1);
    tbl[11] = v({8'h00, 8'h11, 8'h3E}, {2'd1}, 1, 1, 0, 1);
    tbl[12] = v({8'h00, 8'h11, 8'h02}, {2'd1}, 1, 0, 0, 1);
    tbl[13] = v({8'h00, 8'h20, 8'h30}, {20{2'd2}}, 20, 1, 0, 16);
    tbl[14] = v({8'h00, 8'h13, 8'h12}, {2'd0, 2'd3, 2'd2}, 3, 1, 0, 2);

    reset_L = 1'b0; start = 1'b0; nuc = '0; nuc_valid = 1'b0; nuc_last = 1'b0;
    gaps = 1'b0; slen = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    for (int i = 0; i < 32; i++) strm[i] = 0;
    #12;
    chk("reset_outputs", {nuc_ready, busy, done, found, err}, 0);
    chk("reset_pat_addr", pat_addr, 0);
    @(negedge clock); reset_L = 1'b1;
    @(negedge clock);
    chk("idle_outputs", {nuc_ready, busy, done, found, err}, 0);

    for (int t = 0; t < 15; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = tbl[t].pat[i*8 +: 8];
      for (int i = 0; i < 24; i++) strm[i] = int'(tbl[t].str[i*2 +: 2]);
      slen = tbl[t].len;
      gaps = (t % 2 == 1);
      nm = $sformatf("vec%0d", t);
      run_match(nm, cons, fnd, er);
      chk({nm, "_found"}, fnd, tbl[t].f);
      chk({nm, "_err"}, er, tbl[t].e);
      chk({nm, "_consumed"}, cons, tbl[t].c);
    end

    // Reset asserted mid-way through an exact repeat.
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h04; mem[1] = 8'h11;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; nuc_valid = 1'b1; nuc = 2'd1; nuc_last = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_ready", nuc_ready, 1);
    chk("rst_pre_addr", pat_addr, 1);
    #2 reset_L = 1'b0;
    #1;
    chk("rst_mid_outputs", {nuc_ready, busy, done, found, err}, 0);
    chk("rst_mid_addr", pat_addr, 0);
    @(negedge clock); @(negedge clock);
    reset_L = 1'b1;
    r = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (done || busy) r++;
    end
    nuc_valid = 1'b0;
    chk("rst_no_done_no_resume", r, 0);
    strm[0] = 1; strm[1] = 1; strm[2] = 1; strm[3] = 1; slen = 4; gaps = 1'b0;
    run_match("after_rst", cons, fnd, er);
    chk("after_rst_found", fnd, 1);
    chk("after_rst_consumed", cons, 4);

    for (int it = 0; it < 60; it++) begin
      alph = $urandom_range(0, 3);
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      plen = ($urandom_range(0, 9) == 0) ? 16 : $urandom_range(1, 7);
      for (int i = 0; i < plen; i++) begin
        r = $urandom_range(0, 15);
        if (r <= 4)       mem[i] = 8'h10 + 8'($urandom_range(0, alph));
        else if (r <= 6)  mem[i] = 8'h20;
        else if (r == 7)  mem[i] = 8'h21;
        else if (r == 8)  mem[i] = 8'h22;
        else if (r <= 10) mem[i] = 8'($urandom_range(1, 4));
        else if (r <= 12) mem[i] = 8'($urandom_range(8'h3C, 8'h3F));
        else if (r == 13) mem[i] = 8'h30;
        else if (r == 14) mem[i] = ($urandom_range(0, 1) == 0) ? 8'h15 : 8'h40;
        else              mem[i] = (plen == 16) ? 8'h20 : 8'h00;
      end
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) strm[i] = $urandom_range(0, alph);
      slen = len;
      gaps = 1'b1;
      ref_model(mf, me, mc);
      nm = $sformatf("rnd%0d", it);
      run_match(nm, cons, fnd, er);
      chk({nm, "_found"}, fnd, mf);
      chk({nm, "_err"}, er, me);
      chk({nm, "_consumed"}, cons, mc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dna_match_controller.md
DNA_MATCH_CONTROLLER -- requirements
Module: dna_match_controller

Interface
REQ-001 The block SHALL have exactly one clock, `clock`, and SHALL have one reset, `reset_L`, which is asynchronous and active-low.
REQ-002 Parameters SHALL be:
  - NW, default 2, nucleotide width.
  - PW, default 8, pattern entry width.
  - PD, default 16, pattern memory depth.
  - AW = $clog2(PD), derived.
REQ-003 Ports SHALL be (name, direction, width, meaning):
  - clock  in  1  rising-edge clock.
  - reset_L  in  1  async active-low reset.
  - start  in  1  begin anchored match at pattern entry 0.
  - nuc  in  NW  offered nucleotide.
  - nuc_valid  in  1  nuc is valid.
  - nuc_last  in  1  nuc is the final stream symbol.
  - nuc_ready  out  1  nuc consumed this cycle when nuc_valid&&nuc_ready.
  - pat_addr  out  AW  pattern memory read address.
  - pat_data  in  PW  entry at pat_addr, combinational same-cycle read.
  - busy  out  1  match in progress.
  - done  out  1  one-cycle completion pulse.
  - found  out  1  pattern matched, held until next start.
  - err  out  1  malformed pattern, held until next start.

Function
REQ-004 Entry encoding SHALL be:
  - 0x00 END.
  - 0x10-0x13 LIT, nucleotide = entry[1:0].
  - 0x20 ANY.
  - 0x21 ALT2.
  - 0x22 ALT3.
  - 0x01-0x0F EXACT with n = entry[3:0].
  - 0x30-0x3F UPTO with m = 16 - entry[3:0], so 0x30 gives 16; m SHALL be held in a 5-bit count.
  - All other values ILLEGAL.
REQ-005 FSM states SHALL be IDLE, DECODE, CONSUME, ALTLOAD, REP_EXACT, REP_UPTO and FIN; pat_addr SHALL equal the program counter pc at all times.
REQ-006 In IDLE, start=1 SHALL set pc=0, clear found, err and the stream-ended flag, and enter DECODE next cycle with busy=1; start SHALL be ignored when not in IDLE.
REQ-007 nuc_ready SHALL be 1 only in CONSUME, REP_EXACT and REP_UPTO, and only while the stream-ended flag is clear.
REQ-008 A nucleotide SHALL be consumed only on a cycle with nuc_valid&&nuc_ready; when nuc_valid=0 the FSM SHALL hold state, pc and count.
REQ-009 A consumed nucleotide with nuc_last=1 SHALL set the stream-ended flag.
REQ-010 DECODE END SHALL enter FIN with found=1.
REQ-011 DECODE LIT or ANY SHALL enter CONSUME.
REQ-012 In CONSUME, a consumed nucleotide that is a match (ANY matches all) SHALL set pc+1 and return to DECODE; a mismatch SHALL enter FIN with found=0.
REQ-013 DECODE ALT2 or ALT3 SHALL enter ALTLOAD, which increments pc once per cycle and latches the next 2 or 3 entries as candidates.
REQ-014 Any ALT candidate that is not a LIT SHALL enter FIN with err=1.
REQ-015 After the last candidate is latched, ALTLOAD SHALL enter CONSUME; the nucleotide matches if it equals any candidate, and on match pc SHALL advance past the last candidate.
REQ-016 DECODE EXACT SHALL latch count=n, set pc+1 and enter REP_EXACT, whose element is the entry at pc; that element SHALL be LIT or ANY, otherwise FIN with err=1.
REQ-017 REP_EXACT SHALL require count consecutive matching nucleotides, decrementing count per consumed match.
REQ-018 REP_EXACT SHALL enter FIN with found=0 on the first mismatch; at count=0 it SHALL set pc+1 and return to DECODE.
REQ-019 DECODE UPTO SHALL latch count=m, set pc+1 and enter REP_UPTO; the element SHALL obey the same legality rule as REP_EXACT.
REQ-020 REP_UPTO SHALL be greedy with no backtracking:
  - a matching valid nucleotide SHALL be consumed and count decremented.
  - a non-matching valid nucleotide SHALL NOT be consumed (nuc_ready=0); the FSM SHALL set pc+1 and return to DECODE.
  - on count=0 or stream-ended, the FSM SHALL set pc+1 and return to DECODE.
REQ-021 In REP_UPTO, nuc_ready SHALL be combinationally qualified by the match so that a mismatching nucleotide stays offered.
REQ-022 When any state needs a nucleotide, including EXACT with count>0, and the stream-ended flag is set, the FSM SHALL enter FIN with found=0.
REQ-023 DECODE of an ILLEGAL entry, or any pc increment from PD-1, SHALL enter FIN with err=1, found=0; pc SHALL NOT wrap.
REQ-024 FIN SHALL assert done=1 and busy=0 for one cycle, then enter IDLE.
REQ-025 found and err SHALL hold their values until the next accepted start and SHALL never both be 1.
REQ-026 An END entry SHALL yield found=1 even if unconsumed nucleotides remain; matching is prefix-anchored.

Reset
REQ-027 On reset_L=0, the block SHALL asynchronously enter IDLE with pc=0, count=0, candidates=0, the stream-ended flag clear, and outputs nuc_ready=0, busy=0, done=0, found=0, err=0, pat_addr=0.
REQ-028 A reset mid-match SHALL abort the match with no done pulse; operation SHALL resume only on a start after reset_L returns to 1.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
  - Pattern {0x12,0x20,0x00}, stream 2,3(last) -> 2 consumes, done with found=1, err=0.
  - Pattern {0x03,0x11,0x00}, stream 1,1,0 -> mismatch on 3rd symbol, done with found=0; the same pattern with stream 1,1,1 gives found=1.
  - Pattern {0x3D,0x10,0x13,0x00} (m=3), stream 0,0,3 -> 2 consumed in UPTO; the 3 is not consumed there and is then consumed by LIT3; found=1.
  - Pattern {0x22,0x10,0x12,0x13,0x00}, stream 1 -> found=0; stream 2 -> found=1.
  - Pattern {0x15} -> err=1. Pattern {0x21,0x20,...} -> err=1. Sixteen 0x20 entries with no END and a long stream -> err=1 at the pc=15 advance.
  - Pattern {0x10,0x10,0x00}, stream 0(last) -> found=0. Also: reset_L pulsed during REP_EXACT -> all outputs 0 immediately, with no done pulse.
